// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit_pkg
// Description : Shared memory-op encodings, FSM state codes and the alignment
//               helper for the MEM-stage data-memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

    typedef logic [1:0] memop_t;

    localparam memop_t c_MEMOP_WORD = 2'b00;
    localparam memop_t c_MEMOP_HALF = 2'b01;
    localparam memop_t c_MEMOP_BYTE = 2'b10;
    localparam memop_t c_MEMOP_RSVD = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_BUSY = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

    // Reserved size code behaves as a word access, so it shares word alignment.
    function automatic logic is_misaligned(input memop_t op, input logic [1:0] off);
        case (op)
            c_MEMOP_BYTE: return 1'b0;
            c_MEMOP_HALF: return off[0];
            default:      return (off != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Little-endian lane steering: store byte enables and replicated
//               write data, plus load lane extract with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  memOp,
    input  logic [1:0]  offset,
    input  logic        signExt,
    input  logic [31:0] storeData,
    input  logic [31:0] loadWord,
    output logic [3:0]  byteEn,
    output logic [31:0] laneData,
    output logic [31:0] loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        byteEn   = 4'b1111;
        laneData = storeData;
        loadData = loadWord;
        w_byte   = 8'h00;
        w_half   = 16'h0000;
        case (memOp)
            c_MEMOP_BYTE: begin
                byteEn   = 4'b0001 << offset;
                laneData = {4{storeData[7:0]}};
                w_byte   = loadWord[{offset, 3'b000} +: 8];
                loadData = {{24{signExt & w_byte[7]}}, w_byte};
            end
            c_MEMOP_HALF: begin
                // Only offset[1] selects the half; offset[0] is never a lane select.
                byteEn   = offset[1] ? 4'b1100 : 4'b0011;
                laneData = {2{storeData[15:0]}};
                w_half   = offset[1] ? loadWord[31:16] : loadWord[15:0];
                loadData = {{16{signExt & w_half[15]}}, w_half};
            end
            default: begin
                byteEn   = 4'b1111;
                laneData = storeData;
                loadData = loadWord;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM-stage data-memory access unit with req/ack port, pipeline
//               stall and extended load result. Optional misalignment trap is
//               enabled by defining MEM_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic [1:0]  MEM_MemOp,
    input  logic        MEM_MemEXT,
    input  logic [31:0] MEM_aluResult,
    input  logic [31:0] MEM_rfOut2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] MEM_loadData,
    output logic        mem_misalign
);

    state_t      r_state;
    state_t      w_nextState;
    logic        r_we;
    logic        r_isRead;
    logic        r_ext;
    logic        r_misalign;
    memop_t      r_op;
    logic [31:0] r_addr;
    logic [31:0] r_storeData;
    logic [31:0] r_loadData;

    logic        w_access;
    logic        w_misalign;
    logic        w_busy;
    logic        w_ackValid;
    logic        w_capture;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_loadExt;

    assign w_access   = MEM_MemRead | MEM_MemWrite;
    assign w_busy     = (r_state == c_ST_BUSY);
    assign w_ackValid = w_busy & dmem_ack;
    assign w_capture  = (r_state == c_ST_IDLE) & w_access;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = is_misaligned(MEM_MemOp, MEM_aluResult[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        mem_stall   = 1'b0;
        dmem_req    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_access) begin
                    mem_stall   = 1'b1;
                    w_nextState = w_misalign ? c_ST_DONE : c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                mem_stall = 1'b1;
                dmem_req  = 1'b1;
                if (dmem_ack) begin
                    w_nextState = c_ST_DONE;
                end
            end
            // Stall drops here so EX/MEM advances before the next IDLE look.
            c_ST_DONE: w_nextState = c_ST_IDLE;
            default:   w_nextState = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_isRead    <= 1'b0;
            r_ext       <= 1'b0;
            r_misalign  <= 1'b0;
            r_op        <= c_MEMOP_WORD;
            r_addr      <= 32'h0;
            r_storeData <= 32'h0;
            r_loadData  <= 32'h0;
        end else begin
            r_misalign <= 1'b0;
            if (w_capture) begin
                r_we        <= MEM_MemWrite;
                r_isRead    <= MEM_MemRead & ~MEM_MemWrite;
                r_ext       <= MEM_MemEXT;
                r_op        <= MEM_MemOp;
                r_addr      <= MEM_aluResult;
                r_storeData <= MEM_rfOut2;
                if (w_misalign) begin
                    r_misalign <= 1'b1;
                    r_loadData <= 32'h0;
                end
            end
            if (w_ackValid && r_isRead) begin
                r_loadData <= w_loadExt;
            end
        end
    end

    mem_lane_align u_lane_align (
        .memOp     (r_op),
        .offset    (r_addr[1:0]),
        .signExt   (r_ext),
        .storeData (r_storeData),
        .loadWord  (dmem_rdata),
        .byteEn    (w_be),
        .laneData  (w_wdata),
        .loadData  (w_loadExt)
    );

    // Port fields are only driven while a request is outstanding.
    assign dmem_we      = w_busy & r_we;
    assign dmem_addr    = w_busy ? {r_addr[31:2], 2'b00} : 32'h0;
    assign dmem_be      = w_busy ? w_be : 4'b0000;
    assign dmem_wdata   = w_busy ? w_wdata : 32'h0;
    assign MEM_loadData = r_loadData;
    assign mem_misalign = r_misalign;

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage data-memory access unit: the consumer end of the EX/MEM pipeline register. Takes the latched memory-control and operand fields for the instruction in MEM, drives a request/acknowledge data-memory port with byte enables, stalls the pipeline while the access is in flight, and returns the sign- or zero-extended load result toward MEM/WB. Supports byte, halfword and word loads and stores against a variable-latency memory.

## Interface
- No parameters; widths fixed at 32-bit data and address.
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- MEM_MemRead  in  1  load in MEM stage
- MEM_MemWrite  in  1  store in MEM stage
- MEM_MemOp  in  2  size: 00 word, 01 half, 10 byte, 11 reserved (treated as word)
- MEM_MemEXT  in  1  1 = sign-extend loads, 0 = zero-extend
- MEM_aluResult  in  32  effective byte address
- MEM_rfOut2  in  32  store data (low bits used for byte/half)
- dmem_req  out  1  request valid, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({MEM_aluResult[31:2], 2'b00})
- dmem_be  out  4  byte enables, bit i = byte lane i
- dmem_wdata  out  32  lane-replicated store data
- dmem_ack  in  1  access complete; read data valid same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  freeze IF..EX/MEM registers
- MEM_loadData  out  32  extended load result
- mem_misalign  out  1  misaligned-access pulse (only with MEM_ALIGN_CHECK_EN)

## Operation
- FSM states IDLE, BUSY, DONE; reset state IDLE.
- IDLE: access = MEM_MemRead | MEM_MemWrite. If access: mem_stall=1 (combinational), register request fields, go BUSY. Else stay, stall 0.
- BUSY: dmem_req=1, mem_stall=1; fields frozen. On dmem_ack: if read, capture extended dmem_rdata into MEM_loadData; go DONE.
- DONE: mem_stall=0, so EX/MEM advances at end of this cycle; no new request; go IDLE. Prevents re-issuing the same instruction.
- Read and write both high: write only; MEM_loadData unchanged.
- Little-endian lanes, off = MEM_aluResult[1:0]. Byte: be = 1<<off, wdata = {4{rfOut2[7:0]}}. Half: be = off[1] ? 1100 : 0011, wdata = {2{rfOut2[15:0]}}. Word: be = 1111, wdata = rfOut2.
- Load extract uses the same lane; bit 7 or 15 replicated if MEM_MemEXT, else zeros.
- MEM_loadData updates only on read completion; writes leave it unchanged.
- dmem_ack while dmem_req=0 is ignored.

## Timing
- Reset values: all outputs 0, MEM_loadData 0, state IDLE.
- Access visible in cycle 0 -> dmem_req first high cycle 1 -> ack in cycle k>=1 -> DONE cycle k+1 (stall low, loadData valid) -> IDLE k+2.
- Minimum stall: 2 cycles (ack in cycle 1).
- dmem_addr/be/wdata/we stable for every cycle dmem_req is high.
- rst mid-BUSY: IDLE at next edge, dmem_req low, late ack ignored, MEM_loadData cleared.
- Back-to-back accesses: second access starts in the IDLE cycle after DONE.

## Configuration
- MEM_ALIGN_CHECK_EN defined: half with off[0]=1 or word with off!=0 issues no request; IDLE goes directly to DONE (one stall cycle), mem_misalign pulses 1 in DONE, MEM_loadData set to 0.
- Undefined: mem_misalign tied 0; disallowed low address bits are ignored (word uses lanes 0..3, half uses off[1] only).

## Structure
- Shared package: MemOp encodings (MEMOP_WORD/HALF/BYTE), FSM state typedef.
- One sub-module: mem_lane_align (combinational be/wdata generation and load extract/extend), reused by the store and load paths.

## Test plan
- Word store rfOut2=0xDEADBEEF, addr 0x100, ack in cycle 1 -> dmem_be=1111, wdata=0xDEADBEEF, addr=0x100, stall high 2 cycles.
- Byte load addr 0x103, MemEXT=1, rdata=0x80112233, ack after 3 cycles -> be=1000, MEM_loadData=0xFFFFFF80 in DONE, stall 4 cycles.
- Half load addr 0x102, MemEXT=0, rdata=0xBEEF1234 -> be=1100, MEM_loadData=0x0000BEEF.
- Byte store 0x000000AB at addr 0x101 -> be=0010, wdata=0xABABABAB.
- rst asserted mid-BUSY then late ack -> IDLE, req 0, loadData 0, no capture.
- MEM_ALIGN_CHECK_EN: word load addr 0x102 -> no dmem_req, mem_misalign 1 for one cycle, stall 1 cycle, loadData 0.
